// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined single-beat word
// transfers and reports each completed transfer on a one-cycle response strobe.
module ahb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        in_HCLK,
  input  logic        in_HRESETn,
  input  logic        in_cmd_valid,
  output logic        out_cmd_ready,
  input  logic        in_cmd_write,
  input  logic [31:0] in_cmd_addr,
  input  logic [31:0] in_cmd_wdata,
  output logic [31:0] out_HADDR,
  output logic [1:0]  out_HTRANS,
  output logic        out_HWRITE,
  output logic [2:0]  out_HSIZE,
  output logic [2:0]  out_HBURST,
  output logic [31:0] out_HWDATA,
  input  logic        in_HREADY,
  input  logic [31:0] in_HRDATA,
  output logic        out_rsp_valid,
  output logic        out_rsp_write,
  output logic [31:0] out_rsp_rdata,
  output logic        out_busy,
  output logic        out_timeout
);

  localparam int          DATA_W = 32;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              r_valid_p0;
  logic              r_write_p0;
  logic [DATA_W-1:0] r_addr_p0;
  logic [DATA_W-1:0] r_wdata_p0;
  logic              r_valid_p1;
  logic              r_write_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [15:0]       r_wd_cnt;
  logic              r_timeout;
  logic [15:0]       w_wd_nxt;

  assign w_wd_nxt = (r_valid_p1 && !in_HREADY) ? sat_inc(r_wd_cnt) : 16'd0;

  always_ff @(posedge in_HCLK) begin
    if (!in_HRESETn) begin
      r_valid_p0  <= 1'b0;
      r_write_p0  <= 1'b0;
      r_addr_p0   <= '0;
      r_wdata_p0  <= '0;
      r_valid_p1  <= 1'b0;
      r_write_p1  <= 1'b0;
      r_wdata_p1  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      if (TO_LIM != 16'd0 && w_wd_nxt == TO_LIM)
        r_timeout <= 1'b1;
      if (in_HREADY) begin
        // address stage (p0) -> data stage (p1)
        r_valid_p1 <= r_valid_p0;
        r_write_p1 <= r_write_p0;
        r_wdata_p1 <= r_wdata_p0;
        // new command -> address stage (p0); address/direction hold when idle
        r_valid_p0 <= in_cmd_valid;
        if (in_cmd_valid) begin
          r_write_p0 <= in_cmd_write;
          r_addr_p0  <= in_cmd_addr;
          r_wdata_p0 <= in_cmd_wdata;
        end
        // data stage (p1) -> response
        r_rsp_valid <= r_valid_p1;
        if (r_valid_p1) begin
          r_rsp_write <= r_write_p1;
          r_rsp_rdata <= r_write_p1 ? '0 : in_HRDATA;
        end
      end else begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign out_cmd_ready = in_HREADY;
  assign out_HADDR     = r_addr_p0 & ~32'h3;
  assign out_HTRANS    = r_valid_p0 ? 2'b10 : 2'b00;
  assign out_HWRITE    = r_write_p0;
  assign out_HSIZE     = 3'b010;
  assign out_HBURST    = 3'b000;
  assign out_HWDATA    = r_wdata_p1;
  assign out_rsp_valid = r_rsp_valid;
  assign out_rsp_write = r_rsp_write;
  assign out_rsp_rdata = r_rsp_rdata;
  assign out_busy      = r_valid_p0 | r_valid_p1;
  assign out_timeout   = r_timeout;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed-vector bench for ahb_cmd_master with hand-computed expectations.
module tb_ahb_cmd_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  ahb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
    .in_HCLK       (clk),
    .in_HRESETn    (rstn),
    .in_cmd_valid  (cmd_valid),
    .out_cmd_ready (cmd_ready),
    .in_cmd_write  (cmd_write),
    .in_cmd_addr   (cmd_addr),
    .in_cmd_wdata  (cmd_wdata),
    .out_HADDR     (haddr),
    .out_HTRANS    (htrans),
    .out_HWRITE    (hwrite),
    .out_HSIZE     (hsize),
    .out_HBURST    (hburst),
    .out_HWDATA    (hwdata),
    .in_HREADY     (hready),
    .in_HRDATA     (hrdata),
    .out_rsp_valid (rsp_valid),
    .out_rsp_write (rsp_write),
    .out_rsp_rdata (rsp_rdata),
    .out_busy      (busy),
    .out_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    rstn      = 1'b0;
    hready    = 1'b1;
    hrdata    = 32'h0;
    cmd(1'b1, 32'h0000_0055, 32'h1111_2222);

    // reset held with a pending command
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_htrans", 32'(htrans), 32'h0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("hsize", 32'(hsize), 32'h2);
    chk("hburst", 32'(hburst), 32'h0);
    rstn      = 1'b1;
    cmd_valid = 1'b0;
    step();
    chk("idle_htrans", 32'(htrans), 32'h0);

    // single write, zero wait
    cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    step();
    cmd_valid = 1'b0;
    chk("wr_htrans", 32'(htrans), 32'h2);
    chk("wr_haddr", haddr, 32'h0000_1004);
    chk("wr_hwrite", 32'(hwrite), 32'h1);
    chk("wr_busy", 32'(busy), 32'h1);
    step();
    chk("wr_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("wr_htrans_idle", 32'(htrans), 32'h0);
    chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
    step();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_write", 32'(rsp_write), 32'h1);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    step();
    chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("wr_busy_end", 32'(busy), 32'h0);

    // read with two wait states; a write waits for acceptance meanwhile
    cmd(1'b0, 32'h0000_2000, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("rd_htrans", 32'(htrans), 32'h2);
    chk("rd_haddr", haddr, 32'h0000_2000);
    chk("rd_hwrite", 32'(hwrite), 32'h0);
    step();
    hready = 1'b0;
    cmd(1'b1, 32'h0000_2400, 32'hA5A5_0001);
    #1;
    chk("rd_w1_ready", 32'(cmd_ready), 32'h0);
    chk("rd_w1_haddr", haddr, 32'h0000_2000);
    chk("rd_w1_hwrite", 32'(hwrite), 32'h0);
    step();
    chk("rd_w2_ready", 32'(cmd_ready), 32'h0);
    chk("rd_w2_haddr", haddr, 32'h0000_2000);
    chk("rd_w2_htrans", 32'(htrans), 32'h0);
    chk("rd_w2_rsp", 32'(rsp_valid), 32'h0);
    step();
    chk("rd_w3_rsp", 32'(rsp_valid), 32'h0);
    hready = 1'b1;
    hrdata = 32'h1234_5678;
    #1;
    chk("rd_ready_back", 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
    hrdata    = 32'h0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_write", 32'(rsp_write), 32'h0);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_next_htrans", 32'(htrans), 32'h2);
    chk("rd_next_haddr", haddr, 32'h0000_2400);
    chk("rd_next_hwrite", 32'(hwrite), 32'h1);
    step();
    chk("rd_next_hwdata", hwdata, 32'hA5A5_0001);
    chk("rd_next_rsp_gap", 32'(rsp_valid), 32'h0);
    step();
    chk("rd_next_rsp", 32'(rsp_valid), 32'h1);
    chk("rd_next_rsp_w", 32'(rsp_write), 32'h1);
    step();

    // back-to-back W, R, W with an unaligned first address
    cmd(1'b1, 32'h0000_3003, 32'h1111_1111);
    step();
    cmd(1'b0, 32'h0000_4000, 32'h2222_2222);
    chk("b2b_a_htrans", 32'(htrans), 32'h2);
    chk("b2b_a_haddr", haddr, 32'h0000_3000);
    chk("b2b_a_hwrite", 32'(hwrite), 32'h1);
    step();
    cmd(1'b1, 32'h0000_5008, 32'h3333_3333);
    chk("b2b_b_htrans", 32'(htrans), 32'h2);
    chk("b2b_b_haddr", haddr, 32'h0000_4000);
    chk("b2b_b_hwrite", 32'(hwrite), 32'h0);
    chk("b2b_a_hwdata", hwdata, 32'h1111_1111);
    step();
    cmd_valid = 1'b0;
    hrdata    = 32'hCAFE_F00D;
    chk("b2b_c_htrans", 32'(htrans), 32'h2);
    chk("b2b_c_haddr", haddr, 32'h0000_5008);
    chk("b2b_c_hwrite", 32'(hwrite), 32'h1);
    chk("b2b_rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("b2b_rsp1_write", 32'(rsp_write), 32'h1);
    chk("b2b_rsp1_rdata", rsp_rdata, 32'h0);
    step();
    hrdata = 32'h0;
    chk("b2b_idle_htrans", 32'(htrans), 32'h0);
    chk("b2b_c_hwdata", hwdata, 32'h3333_3333);
    chk("b2b_rsp2_valid", 32'(rsp_valid), 32'h1);
    chk("b2b_rsp2_write", 32'(rsp_write), 32'h0);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'hCAFE_F00D);
    step();
    chk("b2b_rsp3_valid", 32'(rsp_valid), 32'h1);
    chk("b2b_rsp3_write", 32'(rsp_write), 32'h1);
    chk("b2b_rsp3_rdata", rsp_rdata, 32'h0);
    step();
    chk("b2b_rsp_end", 32'(rsp_valid), 32'h0);
    chk("b2b_busy_end", 32'(busy), 32'h0);

    // watchdog: six stall cycles against a limit of four
    chk("wd_pre", 32'(timeout), 32'h0);
    cmd(1'b1, 32'h0000_6000, 32'h0000_0077);
    step();
    cmd_valid = 1'b0;
    step();
    hready = 1'b0;
    step();
    step();
    chk("wd_stall3", 32'(timeout), 32'h0);
    step();
    step();
    step();
    chk("wd_stall6", 32'(timeout), 32'h1);
    chk("wd_stall6_rsp", 32'(rsp_valid), 32'h0);
    hready = 1'b1;
    step();
    chk("wd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wd_sticky1", 32'(timeout), 32'h1);
    step();
    step();
    chk("wd_idle_busy", 32'(busy), 32'h0);
    chk("wd_sticky2", 32'(timeout), 32'h1);

    // reset during a read data phase
    cmd(1'b0, 32'h0000_7000, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    hready = 1'b0;
    rstn   = 1'b0;
    step();
    chk("mrst_htrans", 32'(htrans), 32'h0);
    chk("mrst_rsp", 32'(rsp_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_timeout", 32'(timeout), 32'h0);
    chk("mrst_haddr", haddr, 32'h0);
    rstn   = 1'b1;
    hready = 1'b1;
    hrdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_rsp", 32'(rsp_valid), 32'h0);
      chk("mrst_idle", 32'(htrans), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
